pocket_ctrl: RTL and testbench

POCKET_CTRL -- requirements
Module: pocket_ctrl

---
 rtl/pocket_ctrl_if.sv | 21 ++
 rtl/pocket_ctrl.sv | 105 ++++++++++
 tb/tb_pocket_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pocket_ctrl_if.sv
// pocket_ctrl_if: game-side frame/ball inputs and pocket status outputs of the pocket controller
interface pocket_ctrl_if;
  logic        startOfFrame;
  logic [10:0] ballX;
  logic [10:0] ballY;
  logic        ballValid;
  logic        ack;
  logic        busy;
  logic        ballHide;
  logic [4:0]  sinkRadius;
  logic        pocketed;
  logic [2:0]  holeIdx;
  modport master (
    output startOfFrame, ballX, ballY, ballValid, ack,
    input  busy, ballHide, sinkRadius, pocketed, holeIdx
  );
  modport slave (
    input  startOfFrame, ballX, ballY, ballValid, ack,
    output busy, ballHide, sinkRadius, pocketed, holeIdx
  );
endinterface

// File: rtl/pocket_ctrl.sv
// pocket_ctrl: per-frame pocket detection, sink animation and pocket event reporting
module pocket_ctrl #(
  parameter int HOLE_RADIUS = 25,
  parameter int HOLE_X [0:5] = '{32, 320, 608, 32, 320, 608},
  parameter int HOLE_Y [0:5] = '{32, 32, 32, 448, 448, 448},
  parameter int SINK_FRAMES = 16
) (
  input logic clk,
  input logic resetN,
  pocket_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, SINK, REPORT} state_t;
  localparam logic [23:0] R2 = 24'(HOLE_RADIUS * HOLE_RADIUS);
  state_t state, state_n;
  logic [2:0] k, k_n, hole_idx, hole_idx_n;
  logic [10:0] lx, ly, lx_n, ly_n;
  logic [4:0] sink_radius, sink_radius_n;
  logic pocketed, pocketed_n, ball_hide, ball_hide_n, busy, busy_n;
  logic signed [11:0] dx, dy;
  logic signed [23:0] sx, sy;
  logic [23:0] d2;
  logic hit;
  // single distance unit shared across holes, indexed by the scan counter
  always_comb begin
    dx = $signed({1'b0, lx}) - 12'(HOLE_X[k]);
    dy = $signed({1'b0, ly}) - 12'(HOLE_Y[k]);
    sx = dx * dx;
    sy = dy * dy;
    d2 = $unsigned(sx) + $unsigned(sy);
    hit = d2 <= R2;
  end
  // next-state and registered-output values
  always_comb begin
    state_n = state;
    k_n = k;
    lx_n = lx;
    ly_n = ly;
    hole_idx_n = hole_idx;
    sink_radius_n = sink_radius;
    pocketed_n = pocketed;
    ball_hide_n = ball_hide;
    case (state)
      IDLE:
        if (bus.startOfFrame && bus.ballValid) begin
          state_n = SCAN;
          lx_n = bus.ballX;
          ly_n = bus.ballY;
          k_n = '0;
        end
      SCAN:
        if (hit) begin
          state_n = SINK;
          hole_idx_n = k;
          sink_radius_n = 5'(SINK_FRAMES);
        end else if (k == 3'd5) state_n = IDLE;
        else k_n = k + 3'd1;
      SINK:
        if (bus.startOfFrame) begin
          sink_radius_n = sink_radius - 5'd1;
          if (sink_radius == 5'd1) begin
            state_n = REPORT;
            pocketed_n = 1'b1;
            ball_hide_n = 1'b1;
          end
        end
      REPORT:
        if (bus.ack) begin
          state_n = IDLE;
          pocketed_n = 1'b0;
          ball_hide_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  // state and output registers; reset discards any event in flight
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      k <= '0;
      lx <= '0;
      ly <= '0;
      hole_idx <= '0;
      sink_radius <= '0;
      pocketed <= 1'b0;
      ball_hide <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      lx <= lx_n;
      ly <= ly_n;
      hole_idx <= hole_idx_n;
      sink_radius <= sink_radius_n;
      pocketed <= pocketed_n;
      ball_hide <= ball_hide_n;
      busy <= busy_n;
    end
  end
  assign bus.busy = busy;
  assign bus.ballHide = ball_hide;
  assign bus.sinkRadius = sink_radius;
  assign bus.pocketed = pocketed;
  assign bus.holeIdx = hole_idx;
endmodule

// File: tb/tb_pocket_ctrl.sv
// tb_pocket_ctrl: directed scoreboard bench for pocket_ctrl
module tb_pocket_ctrl;
  localparam int SINK_FRAMES = 16;
  typedef struct {int idx; int cycles;} exp_t;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t exp_q[$];
  pocket_ctrl_if bus();
  pocket_ctrl dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic sof();
    bus.startOfFrame = 1'b1;
    @(posedge clk);
    #1 bus.startOfFrame = 1'b0;
    @(negedge clk);
  endtask
  task automatic run_ball(input int x, input int y, input int alt_x, input int exp_idx);
    exp_t e;
    int cyc = 0;
    int got = -2;
    bit done = 0;
    exp_q.push_back('{exp_idx, exp_idx < 0 ? 6 : exp_idx + 1});
    bus.ballX = 11'(x);
    bus.ballY = 11'(y);
    bus.ballValid = 1'b1;
    bus.startOfFrame = 1'b1;
    @(posedge clk);
    #1 bus.startOfFrame = 1'b0;
    if (alt_x >= 0) bus.ballX = 11'(alt_x);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.sinkRadius != 0) begin
        done = 1;
        got = int'(bus.holeIdx);
      end else if (!bus.busy) begin
        done = 1;
        got = -1;
      end else cyc++;
    end
    if (!done) chk("scan_timeout", 0, 1);
    e = exp_q.pop_front();
    chk("hole_idx", got, e.idx);
    chk("scan_cycles", cyc, e.cycles);
    if (e.idx >= 0) begin
      chk("sink_start_radius", bus.sinkRadius, SINK_FRAMES);
      chk("sink_hide", bus.ballHide, 0);
    end else chk("miss_pocketed", bus.pocketed, 0);
  endtask
  task automatic finish_sink(input int idx);
    repeat (SINK_FRAMES - 1) sof();
    chk("sink_last_radius", bus.sinkRadius, 1);
    chk("sink_not_pocketed", bus.pocketed, 0);
    sof();
    chk("report_pocketed", bus.pocketed, 1);
    chk("report_hide", bus.ballHide, 1);
    chk("report_radius", bus.sinkRadius, 0);
    chk("report_idx", bus.holeIdx, idx);
  endtask
  task automatic do_ack();
    bus.ack = 1'b1;
    @(posedge clk);
    #1 bus.ack = 1'b0;
    @(negedge clk);
    chk("ack_pocketed", bus.pocketed, 0);
    chk("ack_hide", bus.ballHide, 0);
    chk("ack_busy", bus.busy, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.startOfFrame = 1'b0;
    bus.ballX = '0;
    bus.ballY = '0;
    bus.ballValid = 1'b0;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hide", bus.ballHide, 0);
    chk("rst_radius", bus.sinkRadius, 0);
    chk("rst_pocketed", bus.pocketed, 0);
    chk("rst_idx", bus.holeIdx, 0);
    resetN = 1'b1;
    @(negedge clk);
    sof();
    chk("invalid_sof_busy", bus.busy, 0);
    run_ball(40, 40, -1, 0);
    bus.ballValid = 1'b0;
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("sink_ack_ignored_busy", bus.busy, 1);
    chk("sink_ack_ignored_radius", bus.sinkRadius, SINK_FRAMES);
    finish_sink(0);
    repeat (100) @(negedge clk);
    chk("report_hold_pocketed", bus.pocketed, 1);
    sof();
    chk("report_sof_pocketed", bus.pocketed, 1);
    chk("report_sof_busy", bus.busy, 1);
    do_ack();
    run_ball(320, 300, -1, -1);
    run_ball(345, 448, -1, 4);
    finish_sink(4);
    do_ack();
    run_ball(346, 448, -1, -1);
    run_ball(600, 440, 40, 5);
    repeat (9) sof();
    chk("mid_sink_radius", bus.sinkRadius, 7);
    #3 resetN = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_hide", bus.ballHide, 0);
    chk("mid_rst_radius", bus.sinkRadius, 0);
    chk("mid_rst_pocketed", bus.pocketed, 0);
    chk("mid_rst_idx", bus.holeIdx, 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_pocketed", bus.pocketed, 0);
    chk("post_rst_busy", bus.busy, 0);
    run_ball(40, 40, -1, 0);
    finish_sink(0);
    do_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
